// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard and sequencing controller for a 5-stage RV32I pipeline.
//             Produces per-stage stall/flush controls for load-use hazards,
//             EX-resolved mispredicts and memory wait states, plus a
//             data-memory wait watchdog and saturating performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             mispredict_EX,
  input  logic             imem_ready,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter must be able to hold TIMEOUT-1.
  localparam int c_WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_WC_W-1:0] c_WC_LAST = c_WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_WC_W-1:0] r_wait_cnt;
  logic              r_fault;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_dwait;
  logic w_loaduse;
  logic w_flush_evt;
  logic w_in_fault;

  assign w_dwait    = dmem_req_MEM & ~dmem_ready;
  assign w_loaduse  = mem_read_EX & (rd_EX != 5'd0) &
                      ((use_rs1_ID & (rd_EX == rs1_ID)) |
                       (use_rs2_ID & (rd_EX == rs2_ID)));
  assign w_in_fault = (r_state == ST_FAULT);

  // Mispredict is only acted on when no data-memory wait is holding EX.
  assign w_flush_evt = ~rst & ~w_in_fault & ~w_dwait & mispredict_EX;

  // Prioritised stall/flush decode from current inputs and state.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushW = 1'b1;
    end else if (w_in_fault || w_dwait) begin
      // Freeze the front of the pipe and drain bubbles into WB.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (mispredict_EX) begin
      // ID instruction is killed, so any load-use on it is irrelevant.
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_loaduse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (!imem_ready) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

  // Watchdog FSM tracking outstanding data-memory wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_dwait) begin
            r_state    <= ST_DWAIT;
            r_wait_cnt <= c_WC_W'(1);
          end
        end
        ST_DWAIT: begin
          if (!dmem_req_MEM || dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_WC_LAST) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          r_fault <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters, frozen while faulted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_in_fault) begin
      if (stallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign fault     = r_fault;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       use_rs1_ID, use_rs2_ID, mem_read_EX, mispredict_EX;
  logic       imem_ready, dmem_req_MEM, dmem_ready;

  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, fault;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_stallF, s_stallD, s_stallE, s_stallM;
  logic        s_flushD, s_flushE, s_flushW, s_fault;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Control vector order: {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
  localparam logic [6:0] c_IDLE  = 7'b0000000;
  localparam logic [6:0] c_RST   = 7'b0000111;
  localparam logic [6:0] c_DWAIT = 7'b1111001;
  localparam logic [6:0] c_MISP  = 7'b0000110;
  localparam logic [6:0] c_LU    = 7'b1100010;
  localparam logic [6:0] c_IMEM  = 7'b1000100;

  logic [6:0] w_ctl;
  logic [6:0] w_s_ctl;
  assign w_ctl   = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
  assign w_s_ctl = {s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW};

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .mispredict_EX(mispredict_EX),
    .imem_ready(imem_ready), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .fault(fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(64), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .mispredict_EX(mispredict_EX),
    .imem_ready(imem_ready), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
    .flushD(s_flushD), .flushE(s_flushE), .flushW(s_flushW), .fault(s_fault),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; mem_read_EX = 1'b0;
    mispredict_EX = 1'b0; imem_ready = 1'b1;
    dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_loaduse();
    mem_read_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    #1;
    chk("reset_ctl", 32'(w_ctl), 32'(c_RST));
    tick();
    tick();
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(w_ctl), 32'(c_IDLE));
    tick();

    // Load-use on rs1, then the same with rd_EX = x0.
    set_loaduse();
    #1;
    chk("lu_ctl", 32'(w_ctl), 32'(c_LU));
    tick();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    rd_EX = 5'd0; rs1_ID = 5'd0;
    #1;
    chk("lu_x0_ctl", 32'(w_ctl), 32'(c_IDLE));
    tick();
    chk("lu_x0_stall_cnt", stall_cnt, 32'd1);
    // Load-use through rs2 only.
    set_idle();
    mem_read_EX = 1'b1; rd_EX = 5'd9; rs2_ID = 5'd9; use_rs2_ID = 1'b1; rs1_ID = 5'd9;
    #1;
    chk("lu_rs2_ctl", 32'(w_ctl), 32'(c_LU));
    use_rs2_ID = 1'b0;
    #1;
    chk("lu_nouse_ctl", 32'(w_ctl), 32'(c_IDLE));
    tick();

    // Mispredict together with load-use.
    do_reset();
    set_loaduse();
    mispredict_EX = 1'b1;
    #1;
    chk("misp_lu_ctl", 32'(w_ctl), 32'(c_MISP));
    tick();
    chk("misp_flush_cnt", flush_cnt, 32'd1);
    chk("misp_stall_cnt", stall_cnt, 32'd0);
    set_idle();

    // Three-cycle DWAIT with deferred mispredict, then completion.
    do_reset();
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0; mispredict_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_loaduse();
      #1;
      chk($sformatf("dwait_ctl_%0d", i), 32'(w_ctl), 32'(c_DWAIT));
      tick();
    end
    set_idle();
    dmem_req_MEM = 1'b1; dmem_ready = 1'b1; mispredict_EX = 1'b1;
    #1;
    chk("dwait_done_ctl", 32'(w_ctl), 32'(c_MISP));
    tick();
    chk("dwait_stall_cnt", stall_cnt, 32'd3);
    chk("dwait_flush_cnt", flush_cnt, 32'd1);
    chk("dwait_fault", 32'(fault), 32'd0);
    set_idle();
    #1;
    chk("dwait_after_ctl", 32'(w_ctl), 32'(c_IDLE));
    tick();

    // Withdrawn request returns to RUN; a fresh 3-cycle wait stays clear of the watchdog.
    do_reset();
    dmem_req_MEM = 1'b1;
    tick();
    tick();
    dmem_req_MEM = 1'b0;
    #1;
    chk("withdraw_ctl", 32'(w_ctl), 32'(c_IDLE));
    tick();
    dmem_req_MEM = 1'b1;
    tick();
    tick();
    tick();
    chk("rewait_fault", 32'(fault), 32'd0);
    dmem_req_MEM = 1'b0;
    tick();

    // Watchdog timeout with TIMEOUT=4.
    do_reset();
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_prefault_%0d", i), 32'(fault), 32'd0);
      tick();
    end
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'd4);
    for (int i = 0; i < 10; i++) begin
      dmem_req_MEM  = i[0];
      dmem_ready    = 1'b1;
      mispredict_EX = ~i[0];
      imem_ready    = i[1];
      if (i > 5) set_loaduse();
      #1;
      chk($sformatf("to_hold_ctl_%0d", i), 32'(w_ctl), 32'(c_DWAIT));
      tick();
    end
    chk("to_frozen_stall", stall_cnt, 32'd4);
    chk("to_frozen_flush", flush_cnt, 32'd0);
    chk("to_sticky", 32'(fault), 32'd1);
    set_idle();
    rst = 1'b1;
    #1;
    chk("to_rst_ctl", 32'(w_ctl), 32'(c_RST));
    tick();
    rst = 1'b0;
    chk("to_rst_fault", 32'(fault), 32'd0);
    chk("to_rst_stall_cnt", stall_cnt, 32'd0);
    chk("to_rst_flush_cnt", flush_cnt, 32'd0);
    set_loaduse();
    #1;
    chk("to_run_ctl", 32'(w_ctl), 32'(c_LU));
    set_idle();
    tick();

    // Instruction-memory wait.
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("imem_ctl_%0d", i), 32'(w_ctl), 32'(c_IMEM));
      tick();
    end
    chk("imem_stall_cnt", stall_cnt, 32'd2);
    set_idle();

    // Saturation on the 3-bit counter instance.
    do_reset();
    chk("sat_start", 32'(s_stall_cnt), 32'd0);
    set_loaduse();
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("sat_ctl_%0d", i), 32'(w_s_ctl), 32'(c_LU));
      tick();
      chk($sformatf("sat_cnt_%0d", i), 32'(s_stall_cnt), (i > 7) ? 32'd7 : 32'(i));
    end
    chk("sat_fault", 32'(s_fault), 32'd0);
    chk("sat_flush_cnt", 32'(s_flush_cnt), 32'd0);
    set_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage stall (hold) and flush (bubble-insert) controls for the inter-stage registers.
- Covers load-use hazards, EX-resolved branch mispredicts, and instruction/data memory wait states.
- Includes a data-memory wait watchdog and saturating performance counters.

Parameters:
- TIMEOUT, 64: maximum DWAIT cycles before fault; legal range ≥2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_ID  in  5  ID-stage source register 1
- rs2_ID  in  5  ID-stage source register 2
- use_rs1_ID  in  1  ID instruction reads rs1
- use_rs2_ID  in  1  ID instruction reads rs2
- rd_EX  in  5  EX-stage destination register
- mem_read_EX  in  1  EX instruction is a load
- mispredict_EX  in  1  branch/jump resolved in EX disagrees with the prediction
- imem_ready  in  1  fetch data valid this cycle
- dmem_req_MEM  in  1  MEM stage has an active load/store
- dmem_ready  in  1  data memory completes this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM registers
- flushD, flushE, flushW  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB
- fault  out  1  sticky data-memory timeout flag
- stall_cnt  out  CNT_W  cycles with stallF=1
- flush_cnt  out  CNT_W  mispredict flush events

Behaviour:
- All stall and flush outputs are combinational from the current inputs and state, with zero-cycle latency. State and counters are registered.
- Polarity: all controls are active-high. Stall has priority over flush on the same register; the pipeline registers implement this.
- Reset (rst=1): state RUN, wait_cnt=0, fault=0, stall_cnt=0, flush_cnt=0. While rst=1: flushD=flushE=flushW=1 and all stalls=0. Reset mid-DWAIT or in FAULT returns to RUN on the next edge.
- Hazard terms:
  - dwait = dmem_req_MEM & ~dmem_ready
  - loaduse = mem_read_EX & (rd_EX≠0) & ((use_rs1_ID & rd_EX==rs1_ID) | (use_rs2_ID & rd_EX==rs2_ID))
- Priority in RUN/DWAIT, first match wins:
  1. dwait: stallF=stallD=stallE=stallM=1, flushW=1. A mispredict or load-use in the same cycle is deferred, because the EX contents are held.
  2. mispredict_EX: flushD=flushE=1, no stalls. Load-use is ignored because the ID instruction is killed.
  3. loaduse: stallF=stallD=1, flushE=1.
  4. ~imem_ready: stallF=1, flushD=1.
  5. Otherwise all outputs are 0.
- FSM:
  - RUN → DWAIT when dwait; wait_cnt←1.
  - DWAIT, dmem_ready=1 → RUN, wait_cnt←0. Outputs in the completing cycle follow priorities 2–5.
  - DWAIT, dwait and wait_cnt==TIMEOUT-1 → FAULT. Otherwise wait_cnt increments.
  - DWAIT, dmem_req_MEM=0 (request withdrawn) → RUN.
  - FAULT: fault=1; stallF/D/E/M=1, flushW=1 regardless of inputs. Only rst exits.
- Counters (saturating at 2^CNT_W-1, never wrapping; frozen in FAULT):
  - stall_cnt increments on every cycle with stallF=1, outside reset.
  - flush_cnt increments on every cycle where priority 2 is selected.

Test Plan:
- Load-use: mem_read_EX=1, rd_EX=5, rs1_ID=5, use_rs1_ID=1, one cycle → stallF=stallD=flushE=1 that cycle; stall_cnt 0→1. Same with rd_EX=0 → all outputs 0.
- Mispredict plus load-use together: mispredict_EX=1 with the load-use inputs above → flushD=flushE=1, stalls 0, flush_cnt +1, stall_cnt unchanged.
- DWAIT of 3 cycles: dmem_req_MEM=1, dmem_ready=0 for 3 cycles, then ready=1 with mispredict_EX=1:
  - Cycles 1–3: all four stalls and flushW=1, mispredict deferred.
  - Cycle 4: flushD=flushE=1, state RUN.
  - stall_cnt=3, flush_cnt=1.
- Timeout: TIMEOUT=4, dmem_ready held 0 → fault=1 after the 4th wait cycle edge; stalls stay 1 for 10 further cycles with counters frozen; rst=1 for 1 cycle → fault=0, counters 0, state RUN.
- Imem wait: imem_ready=0 for 2 cycles, no other hazards → stallF=flushD=1 both cycles; stall_cnt=2.
- Saturation: CNT_W=3, 10 consecutive load-use cycles → stall_cnt sticks at 7.
